// File: rtl/dso_dig_core.sv
// DSO command front end: UART 3-byte commands -> SPI digipot writes -> 1-byte UART response.
// rst_n is a synchronous active-high reset. Optional GAIN_RD_EN adds the gain read-back opcode 8'h0A.
module dso_dig_core #(
  parameter int BAUD_DIV = 434,
  parameter int SPI_DIV  = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic RX,
  output logic TX,
  output logic SCLK,
  output logic MOSI,
  output logic ch1_ss_n,
  output logic ch2_ss_n,
  output logic ch3_ss_n,
  output logic trig_ss_n
);
  localparam logic [15:0] BAUD_M1  = 16'(BAUD_DIV - 1);
  localparam logic [15:0] BAUD_MID = 16'(BAUD_DIV / 2 - 1);
  localparam logic [15:0] HALF_M1  = 16'(SPI_DIV / 2 - 1);
  localparam logic [7:0]  ACK      = 8'hA5;
  localparam logic [7:0]  NAK      = 8'hEE;

  typedef enum logic [1:0] {IDLE, DECODE, SPI_XFER, RESP} state_t;
  state_t state, state_nxt;

  logic        rx_m, rx_s, rx_q, rx_busy, rx_vld;
  logic [15:0] rx_cnt;
  logic [3:0]  rx_bit;
  logic [7:0]  rx_sh;
  logic [1:0]  byte_cnt;
  logic [23:0] cmd;

  logic        dec_spi, dec_gain_we;
  logic [1:0]  dec_sel;
  logic [15:0] dec_word;
  logic [7:0]  dec_resp;
  logic [7:0]  resp_q;
  logic [15:0] spi_word;
  logic [15:0] spi_cnt;
  logic [5:0]  spi_h;
  logic [3:0]  ss_q;
  logic        spi_done;

  logic        tx_busy, tx_done;
  logic [15:0] tx_cnt;
  logic [3:0]  tx_bit;
  logic [8:0]  tx_sh;

  logic [2:0]  gain [3];
  logic        unused_bits;

  wire [7:0] opcode = cmd[23:16];
  wire [7:0] arg1   = cmd[15:8];
  wire [7:0] arg2   = cmd[7:0];
  assign unused_bits = ^arg1[7:5];

  function automatic logic [7:0] pot(input logic [2:0] g);
    case (g)
      3'd0: pot = 8'h02;
      3'd1: pot = 8'h05;
      3'd2: pot = 8'h09;
      3'd3: pot = 8'h14;
      3'd4: pot = 8'h28;
      3'd5: pot = 8'h46;
      3'd6: pot = 8'h6B;
      default: pot = 8'hDD;
    endcase
  endfunction

  // UART receiver: bit 0 is the start bit sampled at mid-bit, 1..8 data, 9 stop
  always_ff @(posedge clk) begin
    rx_vld <= 1'b0;
    if (rst_n) begin
      rx_m <= 1'b1; rx_s <= 1'b1; rx_q <= 1'b1;
      rx_busy <= 1'b0; rx_cnt <= '0; rx_bit <= '0; rx_sh <= '0;
    end else begin
      rx_m <= RX; rx_s <= rx_m; rx_q <= rx_s;
      if (!rx_busy) begin
        if (rx_q && !rx_s) begin
          rx_busy <= 1'b1; rx_cnt <= '0; rx_bit <= '0;
        end
      end else if (rx_cnt == ((rx_bit == 4'd0) ? BAUD_MID : BAUD_M1)) begin
        rx_cnt <= '0;
        rx_bit <= rx_bit + 4'd1;
        if (rx_bit == 4'd0) begin
          if (rx_s) rx_busy <= 1'b0;
        end else if (rx_bit <= 4'd8) begin
          rx_sh <= {rx_s, rx_sh[7:1]};
        end else begin
          rx_busy <= 1'b0;
          rx_vld  <= rx_s;
        end
      end else begin
        rx_cnt <= rx_cnt + 16'd1;
      end
    end
  end

  always_comb begin
    dec_spi     = 1'b0;
    dec_gain_we = 1'b0;
    dec_sel     = arg1[1:0];
    dec_word    = {8'h13, pot(arg1[4:2])};
    dec_resp    = NAK;
    case (opcode)
      8'h02: if (arg1[1:0] != 2'b11) begin
        dec_spi = 1'b1; dec_gain_we = 1'b1; dec_resp = ACK;
      end
      8'h03: if (arg2 >= 8'd46 && arg2 <= 8'd201) begin
        dec_spi = 1'b1; dec_sel = 2'd3; dec_word = {8'h13, arg2}; dec_resp = ACK;
      end
`ifdef GAIN_RD_EN
      8'h0A: if (arg1[1:0] != 2'b11) dec_resp = {5'b0, gain[arg1[1:0]]};
`endif
      default: ;
    endcase
  end

  assign spi_done = (state == SPI_XFER) && (spi_cnt == HALF_M1) && (spi_h == 6'd32);
  assign tx_done  = tx_busy && (tx_bit == 4'd9) && (tx_cnt == BAUD_M1);

  always_ff @(posedge clk) begin
    if (rst_n) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (rx_vld && byte_cnt == 2'd2) state_nxt = DECODE;
      DECODE:   state_nxt = dec_spi ? SPI_XFER : RESP;
      SPI_XFER: if (spi_done) state_nxt = RESP;
      RESP:     if (tx_done) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      byte_cnt <= '0; cmd <= '0; resp_q <= NAK; spi_word <= '0;
      gain[0] <= '0; gain[1] <= '0; gain[2] <= '0;
    end else begin
      if (rx_vld && state == IDLE) begin
        cmd      <= {cmd[15:0], rx_sh};
        byte_cnt <= (byte_cnt == 2'd2) ? 2'd0 : byte_cnt + 2'd1;
      end
      if (state == DECODE) begin
        resp_q   <= dec_resp;
        spi_word <= dec_word;
        if (dec_gain_we) gain[dec_sel] <= arg1[4:2];
      end
    end
  end

  // SPI half-period steps: 0 = porch, odd = SCLK low with new MOSI, even = SCLK high
  always_ff @(posedge clk) begin
    if (rst_n) begin
      ss_q <= 4'hF; SCLK <= 1'b1; MOSI <= 1'b0; spi_cnt <= '0; spi_h <= '0;
    end else if (state == DECODE && dec_spi) begin
      ss_q <= ~(4'b0001 << dec_sel);
      spi_cnt <= '0; spi_h <= '0;
    end else if (state == SPI_XFER) begin
      if (spi_cnt == HALF_M1) begin
        spi_cnt <= '0;
        if (spi_h == 6'd32) begin
          ss_q <= 4'hF; MOSI <= 1'b0;
        end else begin
          spi_h <= spi_h + 6'd1;
          if (!spi_h[0]) begin
            SCLK <= 1'b0;
            MOSI <= spi_word[4'd15 - spi_h[4:1]];
          end else begin
            SCLK <= 1'b1;
          end
        end
      end else begin
        spi_cnt <= spi_cnt + 16'd1;
      end
    end
  end

  assign ch1_ss_n  = ss_q[0];
  assign ch2_ss_n  = ss_q[1];
  assign ch3_ss_n  = ss_q[2];
  assign trig_ss_n = ss_q[3];

  // Response is loaded the cycle after entering RESP, so ss_n is already high
  always_ff @(posedge clk) begin
    if (rst_n) begin
      TX <= 1'b1; tx_busy <= 1'b0; tx_cnt <= '0; tx_bit <= '0; tx_sh <= '1;
    end else if (state == RESP && !tx_busy) begin
      TX <= 1'b0; tx_busy <= 1'b1; tx_cnt <= '0; tx_bit <= '0; tx_sh <= {1'b1, resp_q};
    end else if (tx_busy) begin
      if (tx_cnt == BAUD_M1) begin
        tx_cnt <= '0;
        if (tx_bit == 4'd9) begin
          tx_busy <= 1'b0; TX <= 1'b1;
        end else begin
          tx_bit <= tx_bit + 4'd1;
          TX     <= tx_sh[0];
          tx_sh  <= {1'b1, tx_sh[8:1]};
        end
      end else begin
        tx_cnt <= tx_cnt + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_dso_dig_core.sv
// Directed bench for dso_dig_core: UART commands in, SPI frames and UART responses checked.
module tb_dso_dig_core;
  localparam int BAUD = 16;
  localparam int SPI  = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic RX = 1'b1;
  logic TX, SCLK, MOSI, ch1_ss_n, ch2_ss_n, ch3_ss_n, trig_ss_n;

  int n_vec = 0;
  int n_bad = 0;

  dso_dig_core #(.BAUD_DIV(BAUD), .SPI_DIV(SPI)) dut (
    .clk(clk), .rst_n(rst_n), .RX(RX), .TX(TX), .SCLK(SCLK), .MOSI(MOSI),
    .ch1_ss_n(ch1_ss_n), .ch2_ss_n(ch2_ss_n), .ch3_ss_n(ch3_ss_n), .trig_ss_n(trig_ss_n)
  );

  always #5 clk = ~clk;

  wire [3:0] ss_c = {trig_ss_n, ch3_ss_n, ch2_ss_n, ch1_ss_n};

  logic        mon_en = 1'b0;
  logic [3:0]  ss_p = 4'hF;
  logic        sclk_p = 1'b1;
  logic [15:0] sh = '0;
  int          nb = 0;
  int          frames[4] = '{0, 0, 0, 0};
  logic [15:0] last_word[4];
  int          last_bits[4] = '{0, 0, 0, 0};
  int          overlap = 0;

  // SPI slave model: shift MOSI on each SCLK rise while any select is low
  always @(negedge clk) begin
    if (mon_en) begin
      sclk_p <= SCLK;
      ss_p   <= ss_c;
      if (SCLK && !sclk_p && ss_c != 4'hF) begin
        sh <= {sh[14:0], MOSI};
        nb <= nb + 1;
      end
      for (int i = 0; i < 4; i++)
        if (ss_c[i] && !ss_p[i]) begin
          frames[i]    <= frames[i] + 1;
          last_word[i] <= sh;
          last_bits[i] <= nb;
          nb           <= 0;
        end
      if ($countones(~ss_c) > 1) overlap <= overlap + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    RX = 1'b0;
    repeat (BAUD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (BAUD) @(negedge clk);
    end
    RX = stop_bit;
    repeat (BAUD) @(negedge clk);
    RX = 1'b1;
    if (!stop_bit) repeat (2 * BAUD) @(negedge clk);
  endtask

  task automatic send_cmd(input logic [23:0] c);
    send_byte(c[23:16], 1'b1);
    send_byte(c[15:8], 1'b1);
    send_byte(c[7:0], 1'b1);
  endtask

  task automatic get_resp(output logic [7:0] r, output logic [3:0] ss_at, output logic stopb);
    int t;
    t = 0;
    r = 'x; ss_at = 'x; stopb = 'x;
    @(negedge clk);
    while (TX !== 1'b0 && t < 4000) begin
      @(negedge clk);
      t++;
    end
    if (t < 4000) begin
      ss_at = ss_c;
      repeat (BAUD / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (BAUD) @(negedge clk);
        r[i] = TX;
      end
      repeat (BAUD) @(negedge clk);
      stopb = TX;
    end
  endtask

  // exp_ch: 0 ch1, 1 ch2, 2 ch3, 3 trig, 4 no frame expected
  task automatic do_cmd(input logic [23:0] c, input logic [7:0] exp_resp,
                        input int exp_ch, input logic [15:0] exp_word);
    int f0[4];
    logic [7:0] r;
    logic [3:0] ss_at;
    logic stopb;
    for (int i = 0; i < 4; i++) f0[i] = frames[i];
    fork
      send_cmd(c);
      get_resp(r, ss_at, stopb);
    join
    chk($sformatf("resp %06h", c), {24'h0, r}, {24'h0, exp_resp});
    chk($sformatf("ss_at_tx %06h", c), {28'h0, ss_at}, 32'hF);
    chk($sformatf("tx_stop %06h", c), {31'h0, stopb}, 32'h1);
    for (int i = 0; i < 4; i++)
      chk($sformatf("frames%0d %06h", i, c), frames[i], f0[i] + ((i == exp_ch) ? 1 : 0));
    if (exp_ch < 4) begin
      chk($sformatf("word %06h", c), {16'h0, last_word[exp_ch]}, {16'h0, exp_word});
      chk($sformatf("bits %06h", c), last_bits[exp_ch], 16);
    end
    repeat (BAUD) @(negedge clk);
  endtask

  initial begin
    int t;
    repeat (3) @(negedge clk);
    chk("rst_tx", {31'h0, TX}, 32'h1);
    chk("rst_sclk", {31'h0, SCLK}, 32'h1);
    chk("rst_mosi", {31'h0, MOSI}, 32'h0);
    chk("rst_ss", {28'h0, ss_c}, 32'hF);
    rst_n = 1'b0;
    mon_en = 1'b1;
    repeat (5) @(negedge clk);

    do_cmd(24'h020000, 8'hA5, 0, 16'h1302);
    send_byte(8'h02, 1'b0);
    do_cmd(24'h020500, 8'hA5, 1, 16'h1305);
    do_cmd(24'h020A00, 8'hA5, 2, 16'h1309);
    do_cmd(24'h021100, 8'hA5, 1, 16'h1328);
    do_cmd(24'h021400, 8'hA5, 0, 16'h1346);
    do_cmd(24'h021E00, 8'hA5, 2, 16'h13DD);
    do_cmd(24'h030080, 8'hA5, 3, 16'h1380);
    do_cmd(24'h03002E, 8'hA5, 3, 16'h132E);
    do_cmd(24'h0300C9, 8'hA5, 3, 16'h13C9);
    do_cmd(24'h03002D, 8'hEE, 4, 16'h0);
    do_cmd(24'h0300CA, 8'hEE, 4, 16'h0);
    do_cmd(24'h020300, 8'hEE, 4, 16'h0);
    do_cmd(24'h0F0000, 8'hEE, 4, 16'h0);
    do_cmd(24'h020500, 8'hA5, 1, 16'h1305);
`ifdef GAIN_RD_EN
    do_cmd(24'h0A0100, 8'h01, 4, 16'h0);
    do_cmd(24'h0A0000, 8'h05, 4, 16'h0);
    do_cmd(24'h0A0300, 8'hEE, 4, 16'h0);
`else
    do_cmd(24'h0A0100, 8'hEE, 4, 16'h0);
`endif

    // reset in the middle of an SPI frame
    send_cmd(24'h020000);
    t = 0;
    while (ss_c == 4'hF && t < 2000) begin
      @(negedge clk);
      t++;
    end
    repeat (10) @(negedge clk);
    chk("mid_spi_ss", {28'h0, ss_c}, 32'hE);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_ss", {28'h0, ss_c}, 32'hF);
    chk("rst_mid_tx", {31'h0, TX}, 32'h1);
    chk("rst_mid_sclk", {31'h0, SCLK}, 32'h1);
    rst_n = 1'b0;
    repeat (4 * BAUD) @(negedge clk);
    chk("no_resp_after_rst", {31'h0, TX}, 32'h1);
    do_cmd(24'h021400, 8'hA5, 0, 16'h1346);

    chk("ss_overlap", overlap, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
